deserializer_with_trigger_data: RTL and testbench
=================================================

Name: deserializer_with_trigger_data

Overview:
- Receive-side deserializer model for the ETROC2 readout serial link.
- Samples the serial line one bit per bitCK cycle.
- Splits each bunch-crossing slot into a trigger-data field and a payload field.
- Reassembles the payload into 40-bit frames and the trigger field into a 16-bit trigger word; used as a checker/receiver after the link delay element.

Parameters:
- TRIGW, 16, trigger word width (trigData width).
- FRAMEW, 40, payload frame width (dout width).

Ports:
- bitCK  input  1  bit clock, one serial bit per rising edge (1.28/0.64/0.32 GHz).
- reset  input  1  asynchronous, active-low reset.
- rate  input  2  link rate: 00=320 Mb/s, 01=640 Mb/s, 1x=1280 Mb/s.
- delay  input  5  slot alignment offset in bits.
- sin  input  1  serial data in, MSB-first.
- trigDataSize  input  5  number of trigger bits at the start of each slot (0..16).
- trigData  output  16  last trigger field, right-justified.
- wordTrigClk  output  1  one-cycle strobe, trigData updated.
- word40CK  output  1  one-cycle strobe, dout updated.
- dout  output  40  last assembled payload frame.

Behaviour:
- Single clock domain: bitCK. Async active-low reset; all logic otherwise updates on the rising edge of bitCK.
- Slot length N = 8 (rate 00), 16 (rate 01), 32 (rate 1x).
- Free-running bit counter bitCnt, 0..N-1, wraps to 0 after N-1.
- On a rate change, bitCnt is reduced modulo the new N on the next edge.
- Slot position pos = (bitCnt - delay) mod N. Only delay[4:0] mod N is used.
- Effective trigger size T = min(trigDataSize, 16, N-1). At least one payload bit per slot is always kept.
- Bits at pos 0..T-1 form the trigger field:
  - Shifted into a trigger shift register, first bit landing in the MSB of the T-bit field.
  - On the edge that samples pos = T-1: trigData <= field, zero-extended to 16 bits; wordTrigClk = 1 for that one cycle.
  - T = 0: no trigger capture; trigData holds its value and wordTrigClk stays 0.
- Bits at pos T..N-1 are payload:
  - Shifted into a 40-bit shift register (new bit in LSB) with payload counter pCnt, 0..39.
  - On the edge that samples the 40th payload bit: dout <= completed frame (first-received bit = dout[39]); word40CK = 1 for one cycle; pCnt <= 0.
  - Frames span slot boundaries freely. Trigger bits never enter the payload register and never advance pCnt.
- Latency: a strobe is asserted in the cycle immediately after the edge that samples the last bit; dout/trigData are valid in that same cycle and hold until the next strobe.
- A trigDataSize change takes effect at the next slot start (pos 0). The value is latched at pos 0.
- Reset values: bitCnt=0, pCnt=0, both shift registers 0, dout=0, trigData=0, word40CK=0, wordTrigClk=0.
- Reset mid-frame discards the partial frame/field. After release, counting restarts at bitCnt=0.
- No descrambling and no frame alignment search. Frame alignment is established only by reset release and delay.

Decomposition:
- Shared package: rate encodings (RATE_320=2'b00, RATE_640=2'b01, RATE_1280=2'b1x), slot lengths 8/16/32, FRAMEW=40, TRIGW=16.
- One natural sub-module, ser_shift_capture: a generic width-W shift register with bit counter and done strobe. Instantiated once for the trigger field and once for the payload.

Test Plan:
- Reset: hold reset=0 for 10 bitCK cycles with sin toggling -> dout=0, trigData=0, both strobes 0; first word40CK only after 40 payload bits following release.
- Pure payload: rate=11, trigDataSize=0, delay=0, stream 40'h3C5C3C5A_A5 MSB-first -> word40CK pulses once after bit 40, dout=40'h3C5C3C5AA5; repeated stream gives strobes every 40 cycles.
- Trigger split: rate=11, trigDataSize=3, delay=0, each slot = 3'b101 then 29 payload bits -> wordTrigClk every 32 cycles with trigData=16'h0005; word40CK every 40 payload bits, i.e. frames straddle slots, and dout excludes trigger bits.
- Delay offset: same stream as the trigger-split case but shifted by 5 bits, delay=5 -> identical trigData/dout values to the aligned case.
- Rate 320: rate=00, trigDataSize=20 -> T clamped to 7; 1 payload bit per slot; word40CK every 320 cycles.
- Mid-frame reset: assert reset after 20 payload bits, release, send a full frame 40'hAAAAAAAAAA -> dout=40'hAAAAAAAAAA with no stale bits.

Source files
------------

// File: rtl/deserializer_with_trigger_data_pkg.sv
// Shared constants and helpers for the ETROC2 receive-side deserializer.
// Rate encodings, slot lengths and the trigger-size clamp live here.
package deserializer_with_trigger_data_pkg;

   localparam int unsigned DEF_TRIGW  = 16;
   localparam int unsigned DEF_FRAMEW = 40;

   // Rate 2'b1x means 1280 Mb/s; only bit 1 is examined for that case.
   localparam logic [1:0] RATE_320  = 2'b00;
   localparam logic [1:0] RATE_640  = 2'b01;
   localparam logic [1:0] RATE_1280 = 2'b10;

   localparam int unsigned SLOT_320  = 8;
   localparam int unsigned SLOT_640  = 16;
   localparam int unsigned SLOT_1280 = 32;

   // Slot lengths are powers of two, so N-1 doubles as the modulo mask.
   function automatic logic [4:0] slot_mask(input logic [1:0] rate);
      if (rate[1])
         return 5'(SLOT_1280 - 1);
      else if (rate == RATE_640)
         return 5'(SLOT_640 - 1);
      else
         return 5'(SLOT_320 - 1);
   endfunction

   function automatic logic [4:0] clamp_tsize(input logic [4:0] tds,
                                              input logic [4:0] limit,
                                              input logic [4:0] mask);
      logic [4:0] t;
      t = (tds > limit) ? limit : tds;
      if (t > mask)
         t = mask;
      return t;
   endfunction

endpackage

// File: rtl/deserializer_with_trigger_data_ser.sv
// Generic W-bit MSB-first shift capture with bit counter and done strobe.
// o_done/o_word are combinational for the bit being sampled this cycle.
module ser_shift_capture #(
   parameter int unsigned W  = 40,
   parameter int unsigned CW = 6
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_en,
   input  logic          i_start,
   input  logic          i_bit,
   input  logic [CW-1:0] i_len,
   output logic          o_done,
   output logic [W-1:0]  o_word
);

   logic [W-1:0]  r_sr;
   logic [CW-1:0] r_cnt;
   logic [W-1:0]  w_base;
   logic [CW-1:0] w_cnt;

   // i_start restarts both register and counter from zero on this same bit.
   always_comb begin
      w_base = i_start ? '0 : r_sr;
      w_cnt  = i_start ? '0 : r_cnt;
      o_word = {w_base[W-2:0], i_bit};
      o_done = i_en && (w_cnt == (i_len - CW'(1)));
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sr  <= '0;
         r_cnt <= '0;
      end else if (i_en) begin
         r_sr  <= o_word;
         r_cnt <= o_done ? '0 : (w_cnt + CW'(1));
      end
   end

endmodule

// File: rtl/deserializer_with_trigger_data.sv
// ETROC2 link receiver: splits each slot into trigger field and payload,
// reassembling 40-bit payload frames and a right-justified trigger word.
module deserializer_with_trigger_data
   import deserializer_with_trigger_data_pkg::*;
#(
   parameter int unsigned TRIGW  = DEF_TRIGW,
   parameter int unsigned FRAMEW = DEF_FRAMEW
) (
   input  logic              bitCK,
   input  logic              reset,
   input  logic [1:0]        rate,
   input  logic [4:0]        delay,
   input  logic              sin,
   input  logic [4:0]        trigDataSize,
   output logic [TRIGW-1:0]  trigData,
   output logic              wordTrigClk,
   output logic              word40CK,
   output logic [FRAMEW-1:0] dout
);

   localparam int unsigned PCW = $clog2(FRAMEW + 1);

   logic [4:0]        r_bitcnt;
   logic [4:0]        r_tsize;
   logic [4:0]        w_mask;
   logic [4:0]        w_pos;
   logic [4:0]        w_tnew;
   logic [4:0]        w_tcur;
   logic              w_is_trig;
   logic              w_slot_start;
   logic              w_trig_done;
   logic              w_pay_done;
   logic [TRIGW-1:0]  w_trig_word;
   logic [FRAMEW-1:0] w_pay_word;

   // A new trigger size applies from the pos-0 bit itself, then stays latched.
   always_comb begin
      w_mask       = slot_mask(rate);
      w_pos        = ((r_bitcnt & w_mask) - delay) & w_mask;
      w_slot_start = (w_pos == '0);
      w_tnew       = clamp_tsize(trigDataSize, 5'(TRIGW), w_mask);
      w_tcur       = w_slot_start ? w_tnew :
                     ((r_tsize > w_mask) ? w_mask : r_tsize);
      w_is_trig    = (w_pos < w_tcur);
   end

   ser_shift_capture #(
      .W  (TRIGW),
      .CW (5)
   ) u_trig (
      .i_clk   (bitCK),
      .i_rst_n (reset),
      .i_en    (w_is_trig),
      .i_start (w_slot_start),
      .i_bit   (sin),
      .i_len   (w_tcur),
      .o_done  (w_trig_done),
      .o_word  (w_trig_word)
   );

   ser_shift_capture #(
      .W  (FRAMEW),
      .CW (PCW)
   ) u_pay (
      .i_clk   (bitCK),
      .i_rst_n (reset),
      .i_en    (!w_is_trig),
      .i_start (1'b0),
      .i_bit   (sin),
      .i_len   (PCW'(FRAMEW)),
      .o_done  (w_pay_done),
      .o_word  (w_pay_word)
   );

   always_ff @(posedge bitCK or negedge reset) begin
      if (!reset) begin
         r_bitcnt    <= '0;
         r_tsize     <= '0;
         trigData    <= '0;
         wordTrigClk <= 1'b0;
         word40CK    <= 1'b0;
         dout        <= '0;
      end else begin
         r_bitcnt    <= (r_bitcnt + 5'd1) & w_mask;
         if (w_slot_start)
            r_tsize <= w_tnew;
         wordTrigClk <= w_trig_done;
         word40CK    <= w_pay_done;
         if (w_trig_done)
            trigData <= w_trig_word;
         if (w_pay_done)
            dout <= w_pay_word;
      end
   end

endmodule

// File: tb/tb_deserializer_with_trigger_data.sv
// Self-checking bench for deserializer_with_trigger_data against a
// slot-arithmetic reference model driven with random serial streams.
module tb_deserializer_with_trigger_data;

   logic        bitCK = 1'b0;
   logic        reset = 1'b0;
   logic [1:0]  rate = 2'b11;
   logic [4:0]  delay = '0;
   logic        sin = 1'b0;
   logic [4:0]  trigDataSize = '0;
   logic [15:0] trigData;
   logic        wordTrigClk;
   logic        word40CK;
   logic [39:0] dout;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state: bits since reset release, latched trigger size,
   // collected trigger/payload bits and the expected output values.
   int          k;
   int          tl;
   bit          tq[$];
   bit          pq[$];
   logic [39:0] e_dout;
   logic [15:0] e_trig;
   logic        e_ws;
   logic        e_tc;

   deserializer_with_trigger_data #(
      .TRIGW  (16),
      .FRAMEW (40)
   ) dut (
      .bitCK        (bitCK),
      .reset        (reset),
      .rate         (rate),
      .delay        (delay),
      .sin          (sin),
      .trigDataSize (trigDataSize),
      .trigData     (trigData),
      .wordTrigClk  (wordTrigClk),
      .word40CK     (word40CK),
      .dout         (dout)
   );

   always #5 bitCK = ~bitCK;

   task automatic model_reset();
      k = 0;
      tl = 0;
      tq.delete();
      pq.delete();
      e_dout = '0;
      e_trig = '0;
      e_ws = 1'b0;
      e_tc = 1'b0;
   endtask

   task automatic model_bit(input bit b);
      int n, d, pos;
      logic [39:0] f;
      logic [15:0] tv;
      n = (rate == 2'b00) ? 8 : ((rate == 2'b01) ? 16 : 32);
      d = int'(delay) % n;
      pos = ((k - d) % n + n) % n;
      e_ws = 1'b0;
      e_tc = 1'b0;
      if (pos == 0) begin
         tl = (int'(trigDataSize) > 16) ? 16 : int'(trigDataSize);
         if (tl > n - 1) tl = n - 1;
         tq.delete();
      end
      if (pos < tl) begin
         tq.push_back(b);
         if (tq.size() == tl) begin
            tv = '0;
            foreach (tq[i]) tv = {tv[14:0], tq[i]};
            e_trig = tv;
            e_tc = 1'b1;
            tq.delete();
         end
      end else begin
         pq.push_back(b);
         if (pq.size() == 40) begin
            f = '0;
            foreach (pq[i]) f = {f[38:0], pq[i]};
            e_dout = f;
            e_ws = 1'b1;
            pq.delete();
         end
      end
      k++;
   endtask

   // One bit period: drive at negedge, model the rising edge, sample at next negedge.
   task automatic drive_bit(input bit b);
      sin = b;
      @(posedge bitCK);
      if (reset) model_bit(b);
      @(negedge bitCK);
      n_cmp++;
      if (word40CK !== e_ws) begin
         n_bad++;
         $display("FAIL word40CK k=%0d got %b want %b", k, word40CK, e_ws);
      end
      n_cmp++;
      if (wordTrigClk !== e_tc) begin
         n_bad++;
         $display("FAIL wordTrigClk k=%0d got %b want %b", k, wordTrigClk, e_tc);
      end
      n_cmp++;
      if (dout !== e_dout) begin
         n_bad++;
         $display("FAIL dout k=%0d got %h want %h", k, dout, e_dout);
      end
      n_cmp++;
      if (trigData !== e_trig) begin
         n_bad++;
         $display("FAIL trigData k=%0d got %h want %h", k, trigData, e_trig);
      end
   endtask

   task automatic apply_reset(input logic [1:0] r, input logic [4:0] d, input logic [4:0] t);
      reset = 1'b0;
      rate = r;
      delay = d;
      trigDataSize = t;
      model_reset();
      for (int i = 0; i < 3; i++) drive_bit(bit'($urandom_range(0, 1)));
      reset = 1'b1;
   endtask

   task automatic test_reset();
      int pulses;
      reset = 1'b0;
      rate = 2'b11;
      delay = '0;
      trigDataSize = '0;
      model_reset();
      for (int i = 0; i < 10; i++) begin
         drive_bit(bit'(i % 2));
         n_cmp++;
         if ({dout, trigData, word40CK, wordTrigClk} !== 58'd0) begin
            n_bad++;
            $display("FAIL reset_hold got dout=%h trig=%h ws=%b tc=%b want all 0",
                     dout, trigData, word40CK, wordTrigClk);
         end
      end
      reset = 1'b1;
      pulses = 0;
      for (int i = 0; i < 39; i++) begin
         drive_bit(bit'($urandom_range(0, 1)));
         if (word40CK) pulses++;
      end
      n_cmp++;
      if (pulses != 0) begin
         n_bad++;
         $display("FAIL early_frame got %0d strobes want 0", pulses);
      end
      drive_bit(bit'($urandom_range(0, 1)));
      n_cmp++;
      if (word40CK !== 1'b1) begin
         n_bad++;
         $display("FAIL first_frame got %b want 1", word40CK);
      end
   endtask

   task automatic test_pure_payload();
      logic [39:0] pat;
      pat = 40'h3C5C3C5AA5;
      apply_reset(2'b11, 5'd0, 5'd0);
      for (int rep = 0; rep < 3; rep++) begin
         for (int i = 39; i >= 0; i--) drive_bit(pat[i]);
         n_cmp++;
         if (word40CK !== 1'b1 || dout !== pat) begin
            n_bad++;
            $display("FAIL pure_payload rep=%0d got ws=%b dout=%h want 1 %h", rep, word40CK, dout, pat);
         end
      end
   endtask

   task automatic test_trigger_split(input logic [4:0] d);
      int tp, fp;
      apply_reset(2'b11, d, 5'd3);
      tp = 0;
      fp = 0;
      for (int i = 0; i < int'(d); i++) begin
         drive_bit(bit'($urandom_range(0, 1)));
         if (word40CK) fp++;
      end
      for (int s = 0; s < 8; s++) begin
         for (int i = 0; i < 32; i++) begin
            drive_bit((i == 0 || i == 2) ? 1'b1 : ((i == 1) ? 1'b0 : bit'($urandom_range(0, 1))));
            if (word40CK) fp++;
            if (wordTrigClk) begin
               tp++;
               n_cmp++;
               if (trigData !== 16'h0005) begin
                  n_bad++;
                  $display("FAIL trig_split d=%0d got %h want 0005", d, trigData);
               end
            end
         end
      end
      n_cmp++;
      if (tp != 8) begin
         n_bad++;
         $display("FAIL trig_count d=%0d got %0d want 8", d, tp);
      end
      n_cmp++;
      if (fp != (8 * 29 + int'(d)) / 40) begin
         n_bad++;
         $display("FAIL frame_count d=%0d got %0d want %0d", d, fp, (8 * 29 + int'(d)) / 40);
      end
   endtask

   task automatic test_rate320();
      int tp, fp;
      apply_reset(2'b00, 5'd0, 5'd20);
      tp = 0;
      fp = 0;
      for (int i = 0; i < 660; i++) begin
         drive_bit(bit'($urandom_range(0, 1)));
         if (word40CK) fp++;
         if (wordTrigClk) tp++;
         if (i == 319 || i == 639) begin
            n_cmp++;
            if (word40CK !== 1'b1) begin
               n_bad++;
               $display("FAIL rate320_frame i=%0d got %b want 1", i, word40CK);
            end
         end
      end
      n_cmp++;
      if (fp != 2 || tp != 82) begin
         n_bad++;
         $display("FAIL rate320_counts got frames=%0d trigs=%0d want 2 82", fp, tp);
      end
   endtask

   task automatic test_midframe_reset();
      logic [39:0] pat;
      pat = 40'hAAAAAAAAAA;
      apply_reset(2'b11, 5'd0, 5'd0);
      for (int i = 0; i < 20; i++) drive_bit(1'b1);
      reset = 1'b0;
      model_reset();
      drive_bit(1'b1);
      drive_bit(1'b1);
      reset = 1'b1;
      for (int i = 39; i >= 0; i--) drive_bit(pat[i]);
      n_cmp++;
      if (word40CK !== 1'b1 || dout !== pat) begin
         n_bad++;
         $display("FAIL midframe_reset got ws=%b dout=%h want 1 %h", word40CK, dout, pat);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 6; it++) begin
         apply_reset(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
         for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 49) == 0) trigDataSize = 5'($urandom_range(0, 31));
            drive_bit(bit'($urandom_range(0, 1)));
         end
      end
   endtask

   initial begin
      @(negedge bitCK);
      test_reset();
      test_pure_payload();
      test_trigger_split(5'd0);
      test_trigger_split(5'd5);
      test_rate320();
      test_midframe_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
